// File: rtl/cam_frame_capture.sv
// OV7670 capture front end: resynchronises the camera bus into clk, packs two bytes per
// RGB444 pixel and writes one complete frame linearly into the frame buffer.
module cam_frame_capture #(
  parameter int N_ROWS = 120,
  parameter int N_COLS = 160,
  parameter int AW     = 15,
  parameter int DW     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_capture,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] cap_addr_out,
  output logic [DW-1:0] cap_data_out,
  output logic          cap_we,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int              N_PIX     = N_ROWS * N_COLS;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(N_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_SOF,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Two-flop synchronisers for the camera bus.
  logic       pclk_s1, pclk_s2, pclk_d;
  logic       vsync_s1, vsync_s2, vsync_d;
  logic       href_s1, href_s2, href_d;
  logic [7:0] data_s1, data_s2;

  // Registered event stage: every camera event the FSM sees is aligned here.
  logic       ev_pclk_rise, ev_href, ev_href_fall;
  logic       ev_vsync, ev_vsync_rise, ev_vsync_fall;
  logic [7:0] ev_data;

  logic       init_d;
  logic       init_rise;

  logic       phase;
  logic [3:0] hi_nib;
  logic       full;

  assign init_rise = init_capture & ~init_d;

  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  // the same pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_s1       <= 1'b0;
      pclk_s2       <= 1'b0;
      pclk_d        <= 1'b0;
      vsync_s1      <= 1'b0;
      vsync_s2      <= 1'b0;
      vsync_d       <= 1'b0;
      href_s1       <= 1'b0;
      href_s2       <= 1'b0;
      href_d        <= 1'b0;
      data_s1       <= '0;
      data_s2       <= '0;
      ev_pclk_rise  <= 1'b0;
      ev_href       <= 1'b0;
      ev_href_fall  <= 1'b0;
      ev_vsync      <= 1'b0;
      ev_vsync_rise <= 1'b0;
      ev_vsync_fall <= 1'b0;
      ev_data       <= '0;
      init_d        <= 1'b0;
    end else begin
      pclk_s1       <= cam_pclk;
      pclk_s2       <= pclk_s1;
      pclk_d        <= pclk_s2;
      vsync_s1      <= cam_vsync;
      vsync_s2      <= vsync_s1;
      vsync_d       <= vsync_s2;
      href_s1       <= cam_href;
      href_s2       <= href_s1;
      href_d        <= href_s2;
      data_s1       <= cam_data;
      data_s2       <= data_s1;
      // Data and href come from the same stage as the pclk edge they belong to.
      ev_pclk_rise  <= pclk_s2 & ~pclk_d;
      ev_href       <= href_s2;
      ev_href_fall  <= ~href_s2 & href_d;
      ev_vsync      <= vsync_s2;
      ev_vsync_rise <= vsync_s2 & ~vsync_d;
      ev_vsync_fall <= ~vsync_s2 & vsync_d;
      ev_data       <= data_s2;
      init_d        <= init_capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state and outputs get defaults before the case so no path
  // leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (init_rise) state_nxt = S_ARM;
      end
      S_ARM: begin
        busy = 1'b1;
        if (ev_vsync) state_nxt = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        busy = 1'b1;
        if (ev_vsync_fall) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy = 1'b1;
        if (ev_vsync_rise) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (init_rise) state_nxt = S_ARM;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pixel assembly and write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr_out <= '0;
      cap_data_out <= '0;
      cap_we       <= 1'b0;
      overflow     <= 1'b0;
      phase        <= 1'b0;
      hi_nib       <= '0;
      full         <= 1'b0;
    end else begin
      cap_we <= 1'b0;

      // The address moves on only after the write strobe has used it; the last
      // location is sticky so an oversize frame can never wrap onto pixel 0.
      if (cap_we) begin
        if (cap_addr_out == LAST_ADDR) full <= 1'b1;
        else                           cap_addr_out <= cap_addr_out + 1'b1;
      end

      if (state == S_CAPTURE && !ev_vsync_rise) begin
        if (ev_href_fall) begin
          phase <= 1'b0;
        end else if (ev_pclk_rise && ev_href) begin
          if (!phase) begin
            hi_nib <= ev_data[3:0];
            phase  <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (full) begin
              overflow <= 1'b1;
            end else begin
              cap_we       <= 1'b1;
              cap_data_out <= DW'({hi_nib, ev_data});
            end
          end
        end
      end

      if (state == S_WAIT_SOF && ev_vsync_fall) begin
        cap_addr_out <= '0;
        phase        <= 1'b0;
        overflow     <= 1'b0;
        full         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: a byte-level OV7670 driver feeds a scoreboard of expected
// frame-buffer writes, and a monitor retires each cap_we against it. Frame size is reduced.
module tb_cam_frame_capture;

  localparam int N_ROWS = 8;
  localparam int N_COLS = 12;
  localparam int AW     = 15;
  localparam int DW     = 12;
  localparam int N_PIX  = N_ROWS * N_COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_capture;
  logic          cam_pclk, cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic [AW-1:0] cap_addr_out;
  logic [DW-1:0] cap_data_out;
  logic          cap_we, busy, done, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int last_addr = -1;

  logic [AW+DW-1:0] exp_q[$];

  cam_frame_capture #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .AW(AW), .DW(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_capture (init_capture),
    .cam_pclk     (cam_pclk),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_data     (cam_data),
    .cap_addr_out (cap_addr_out),
    .cap_data_out (cap_data_out),
    .cap_we       (cap_we),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (cap_we === 1'b1) begin
      logic [AW+DW-1:0] exp_w;
      n_writes++;
      last_addr = int'(cap_addr_out);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%03h, expected no write", cap_addr_out, cap_data_out);
      end else begin
        exp_w = exp_q.pop_front();
        if ({cap_addr_out, cap_data_out} !== exp_w) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0d data=%03h, expected addr=%0d data=%03h",
                   cap_addr_out, cap_data_out, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  // One camera byte: pclk low for 2 clk with data set up, then high for 2 clk.
  task automatic cam_byte(input logic h, input logic [7:0] d);
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_href = h;
    cam_data = d;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_bytes(input int n);
    for (int i = 0; i < n; i++) cam_byte(1'b0, 8'h00);
  endtask

  task automatic arm();
    @(negedge clk);
    init_capture = 1'b1;
    @(negedge clk);
    init_capture = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Whole frame: vsync pulse, n_lines of N_COLS pixels, closing vsync rise.
  // odd_line gets one extra byte; arm_line pulses init at that line's start;
  // rst_pix asserts reset just before that pixel index.
  task automatic send_frame(input int n_lines, input int odd_line, input int arm_line,
                            input bit exp_en, input int rst_pix, input int base);
    int p = 0;
    bit exp_on = exp_en;
    @(negedge clk);
    cam_vsync = 1'b1;
    idle_bytes(2);
    @(negedge clk);
    cam_vsync = 1'b0;
    idle_bytes(2);
    for (int l = 0; l < n_lines; l++) begin
      if (l == arm_line) arm();
      for (int c = 0; c < N_COLS; c++) begin
        logic [11:0] d;
        logic [3:0]  junk;
        if (p == rst_pix) begin
          repeat (5) @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          n_checks++;
          if ({cap_addr_out, cap_data_out, cap_we, busy, done, overflow} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got addr=%0d data=%03h we=%b busy=%b done=%b ovf=%b, expected all 0",
                     cap_addr_out, cap_data_out, cap_we, busy, done, overflow);
          end
          rst    = 1'b0;
          exp_on = 1'b0;
        end
        d    = 12'(p + base);
        junk = 4'($urandom_range(15));
        if (exp_on && p < N_PIX) exp_q.push_back({AW'(p), d});
        cam_byte(1'b1, {junk, d[11:8]});
        cam_byte(1'b1, d[7:0]);
        p++;
      end
      if (l == odd_line) cam_byte(1'b1, 8'hF5);
      idle_bytes(3);
    end
    @(negedge clk);
    cam_vsync = 1'b1;
    idle_bytes(3);
    check_int("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    init_capture = 1'b0;
    cam_pclk     = 1'b0;
    cam_vsync    = 1'b0;
    cam_href     = 1'b0;
    cam_data     = 8'h00;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({cap_addr_out, cap_data_out, cap_we, busy, done, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0d data=%03h we=%b busy=%b done=%b ovf=%b, expected all 0",
               cap_addr_out, cap_data_out, cap_we, busy, done, overflow);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("idle_busy", busy, 1'b0);
  endtask

  task automatic test_full_frame();
    n_writes = 0;
    arm();
    check_bit("arm_busy", busy, 1'b1);
    // init pulse at line 3 lands in CAPTURE and must not disturb the frame
    send_frame(N_ROWS, -1, 3, 1'b1, -1, 0);
    check_bit("full_done", done, 1'b1);
    check_bit("full_busy", busy, 1'b0);
    check_bit("full_overflow", overflow, 1'b0);
    check_int("full_write_count", n_writes, N_PIX);
    check_int("full_last_addr", last_addr, N_PIX - 1);
  endtask

  task automatic test_arm_mid_frame();
    n_writes = 0;
    send_frame(N_ROWS, -1, 2, 1'b0, -1, 300);
    check_int("midarm_no_writes", n_writes, 0);
    check_bit("midarm_busy", busy, 1'b1);
    check_bit("midarm_done", done, 1'b0);
    send_frame(N_ROWS, -1, -1, 1'b1, -1, 700);
    check_int("midarm_write_count", n_writes, N_PIX);
    check_bit("midarm_final_done", done, 1'b1);
  endtask

  task automatic test_odd_line();
    n_writes = 0;
    arm();
    send_frame(N_ROWS, 4, -1, 1'b1, -1, 1100);
    check_int("odd_write_count", n_writes, N_PIX);
    check_bit("odd_done", done, 1'b1);
    check_bit("odd_overflow", overflow, 1'b0);
  endtask

  task automatic test_oversize();
    n_writes = 0;
    arm();
    send_frame(N_ROWS + 1, -1, -1, 1'b1, -1, 2000);
    check_int("over_write_count", n_writes, N_PIX);
    check_int("over_last_addr", last_addr, N_PIX - 1);
    check_bit("over_overflow", overflow, 1'b1);
    check_bit("over_done", done, 1'b1);
  endtask

  task automatic test_restart_reset();
    n_writes = 0;
    @(negedge clk);
    init_capture = 1'b1;
    @(negedge clk);
    check_bit("restart_done_clear", done, 1'b0);
    check_bit("restart_busy", busy, 1'b1);
    send_frame(N_ROWS, -1, -1, 1'b1, -1, 2500);
    check_int("restart_write_count", n_writes, N_PIX);
    check_bit("restart_overflow_cleared", overflow, 1'b0);
    repeat (10) @(negedge clk);
    check_bit("held_init_no_rearm", done, 1'b1);
    init_capture = 1'b0;
    n_writes = 0;
    arm();
    send_frame(N_ROWS, -1, -1, 1'b1, N_PIX / 2, 3000);
    check_int("reset_write_count", n_writes, N_PIX / 2);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
  endtask

  task automatic test_latency();
    n_writes = 0;
    arm();
    @(negedge clk);
    cam_vsync = 1'b1;
    idle_bytes(2);
    @(negedge clk);
    cam_vsync = 1'b0;
    idle_bytes(2);
    exp_q.push_back({AW'(0), 12'hABC});
    cam_byte(1'b1, 8'h5A);
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_data = 8'hBC;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check_bit($sformatf("latency_we_edge%0d", i), cap_we, (i == 4));
    end
    check_int("latency_data", int'(cap_data_out), 12'hABC);
    check_int("latency_addr", int'(cap_addr_out), 0);
    idle_bytes(2);
    @(negedge clk);
    cam_vsync = 1'b1;
    idle_bytes(3);
    check_bit("latency_done", done, 1'b1);
    check_int("latency_write_count", n_writes, 1);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_arm_mid_frame();
    test_odd_line();
    test_oversize();
    test_restart_reset();
    test_latency();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
